time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/clock_pkg.sv | 61 ++++++
 rtl/btn_debounce.sv | 54 +++++
 rtl/time_set_ctrl.sv | 140 ++++++++++++++
 tb/tb_time_set_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared FSM encodings, time limits, reset time and digit-advance helpers
package clock_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_SET_HRS  = 2'd1;
    localparam logic [1:0] ST_SET_MINS = 2'd2;

    localparam logic [5:0] SEC_MAX       = 6'd59;
    localparam logic [2:0] MIN_TENS_MAX  = 3'd5;
    localparam logic [3:0] DIGIT_MAX     = 4'd9;
    localparam logic [2:0] HRS_TENS_MAX  = 3'd1;
    localparam logic [3:0] HRS_ONES_MAX  = 4'd2;
    localparam logic [3:0] HRS_ONES_MIN  = 4'd1;

    localparam logic [2:0] RST_HRS_TENS  = 3'd1;
    localparam logic [3:0] RST_HRS_ONES  = 4'd2;
    localparam logic [2:0] RST_MINS_TENS = 3'd0;
    localparam logic [3:0] RST_MINS_ONES = 4'd0;

    typedef struct packed {
        logic [2:0] hrs_tens;
        logic [3:0] hrs_ones;
        logic [2:0] mins_tens;
        logic [3:0] mins_ones;
    } time_t;

    localparam time_t RST_TIME = '{RST_HRS_TENS, RST_HRS_ONES, RST_MINS_TENS, RST_MINS_ONES};

    function automatic logic mins_at_max(input time_t t);
        return (t.mins_tens == MIN_TENS_MAX) && (t.mins_ones == DIGIT_MAX);
    endfunction

    // 12 wraps to 1, 9 carries into the tens digit.
    function automatic time_t next_hour(input time_t t);
        time_t r;
        r = t;
        if (t.hrs_tens == HRS_TENS_MAX && t.hrs_ones == HRS_ONES_MAX) begin
            r.hrs_tens = 3'd0;
            r.hrs_ones = HRS_ONES_MIN;
        end else if (t.hrs_ones == DIGIT_MAX) begin
            r.hrs_tens = t.hrs_tens + 3'd1;
            r.hrs_ones = 4'd0;
        end else begin
            r.hrs_ones = t.hrs_ones + 4'd1;
        end
        return r;
    endfunction

    function automatic time_t next_min(input time_t t);
        time_t r;
        r = t;
        if (t.mins_ones == DIGIT_MAX) begin
            r.mins_ones = 4'd0;
            r.mins_tens = (t.mins_tens == MIN_TENS_MAX) ? 3'd0 : t.mins_tens + 3'd1;
        end else begin
            r.mins_ones = t.mins_ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, stable-count debouncer and single-cycle press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Level flips on the last of DEBOUNCE_CYCLES consecutive differing cycles.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - 12-hour clock with two-button set FSM; TIME_SET_BLINK_EN adds set-digit blinking
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [2:0] hrs_tens,
    output logic [3:0] hrs_ones,
    output logic [2:0] mins_tens,
    output logic [3:0] mins_ones,
    output logic       blank_hrs,
    output logic       blank_mins
);

    localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic              mode_p, inc_p;
    logic [1:0]        state_q, state_d;
    time_t             time_q, time_d;
    logic [5:0]        sec_q, sec_d;
    logic [TICK_W-1:0] tick_q, tick_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk     (clk_100MHz),
        .rst     (reset),
        .btn_raw (btn_mode),
        .press   (mode_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk     (clk_100MHz),
        .rst     (reset),
        .btn_raw (btn_inc),
        .press   (inc_p)
    );

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        sec_d   = sec_q;
        tick_d  = tick_q;
        case (state_q)
            ST_RUN: begin
                if (mode_p) state_d = ST_SET_HRS;
                if (tick_q == TICK_W'(CLK_HZ - 1)) begin
                    tick_d = '0;
                    if (sec_q == SEC_MAX) begin
                        sec_d  = '0;
                        time_d = mins_at_max(time_q) ? next_hour(next_min(time_q)) : next_min(time_q);
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            ST_SET_HRS: begin
                if (mode_p)     state_d = ST_SET_MINS;
                else if (inc_p) time_d  = next_hour(time_q);
            end
            ST_SET_MINS: begin
                // Leaving set mode starts the new minute from a clean zero.
                if (mode_p) begin
                    state_d = ST_RUN;
                    sec_d   = '0;
                    tick_d  = '0;
                end else if (inc_p) begin
                    time_d = next_min(time_q);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            time_q  <= RST_TIME;
            sec_q   <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            sec_q   <= sec_d;
            tick_q  <= tick_d;
        end
    end

    assign hrs_tens  = time_q.hrs_tens;
    assign hrs_ones  = time_q.hrs_ones;
    assign mins_tens = time_q.mins_tens;
    assign mins_ones = time_q.mins_ones;

`ifdef TIME_SET_BLINK_EN
    localparam int HALF_HZ = (CLK_HZ > 3) ? CLK_HZ / 2 : 2;

    logic              blink_q, blink_d;
    logic [TICK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic              inc_taken;

    assign inc_taken = inc_p && !mode_p && (state_q != ST_RUN);

    // Phase restarts visible whenever the user acts, so the edited digit shows at once.
    always_comb begin
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (state_q == ST_RUN || state_d != state_q || inc_taken) begin
            blink_d     = 1'b0;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == TICK_W'(HALF_HZ - 1)) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end else begin
            blink_cnt_d = blink_cnt_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign blank_hrs  = blink_q && (state_q == ST_SET_HRS);
    assign blank_mins = blink_q && (state_q == ST_SET_MINS);
`else
    assign blank_hrs  = 1'b0;
    assign blank_mins = 1'b0;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed self-checking bench for time_set_ctrl (CLK_HZ=10, DEBOUNCE_CYCLES=4)
module tb_time_set_ctrl;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic       btn_mode;
    logic       btn_inc;
    logic [2:0] hrs_tens;
    logic [3:0] hrs_ones;
    logic [2:0] mins_tens;
    logic [3:0] mins_ones;
    logic       blank_hrs;
    logic       blank_mins;

    int n_checks = 0;
    int n_errors = 0;

    time_set_ctrl #(.CLK_HZ(10), .DEBOUNCE_CYCLES(4)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .hrs_tens   (hrs_tens),
        .hrs_ones   (hrs_ones),
        .mins_tens  (mins_tens),
        .mins_ones  (mins_ones),
        .blank_hrs  (blank_hrs),
        .blank_mins (blank_mins)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_time(input string tag, input int ht, input int ho, input int mt, input int mo);
        check_eq({tag, ".hrs_tens"},  int'(hrs_tens),  ht);
        check_eq({tag, ".hrs_ones"},  int'(hrs_ones),  ho);
        check_eq({tag, ".mins_tens"}, int'(mins_tens), mt);
        check_eq({tag, ".mins_ones"}, int'(mins_ones), mo);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    // which: 0 = mode, 1 = inc; long enough hold and release for full debounce
    task automatic press(input int which);
        if (which == 0) btn_mode = 1'b1; else btn_inc = 1'b1;
        cycles(8);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cycles(8);
    endtask

    // Mode pulse is consumed on edge 7 after the raw press; first minute lands 600 edges later.
    task automatic mode_to_run(input string tag, input int b_ht, input int b_ho, input int b_mt, input int b_mo,
                               input int a_ht, input int a_ho, input int a_mt, input int a_mo);
        btn_mode = 1'b1;
        cycles(7);
        cycles(10);
        btn_mode = 1'b0;
        cycles(589);
        expect_time({tag, ".599"}, b_ht, b_ho, b_mt, b_mo);
        cycles(1);
        expect_time({tag, ".600"}, a_ht, a_ho, a_mt, a_mo);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, limit 50000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cycles(3);
        expect_time("reset", 1, 2, 0, 0);
        check_eq("reset.blank_hrs",  int'(blank_hrs),  0);
        check_eq("reset.blank_mins", int'(blank_mins), 0);
        reset = 1'b0;

        cycles(599);
        expect_time("run.599", 1, 2, 0, 0);
        cycles(1);
        expect_time("run.600", 1, 2, 0, 1);

        // preload 12:59 and roll to 1:00
        press(0);
        press(0);
        expect_time("set_mins_entry", 1, 2, 0, 1);
        repeat (58) press(1);
        expect_time("preload_1259", 1, 2, 5, 9);
        mode_to_run("roll_12_1", 1, 2, 5, 9, 0, 1, 0, 0);

        // preload 9:59, also exercising the 59 -> 00 wrap in SET_MINS
        press(0);
        repeat (8) press(1);
        expect_time("set_hrs_9", 0, 9, 0, 0);
        press(0);
        repeat (59) press(1);
        expect_time("set_mins_59", 0, 9, 5, 9);
        press(1);
        expect_time("mins_wrap_no_carry", 0, 9, 0, 0);
        repeat (59) press(1);
        mode_to_run("roll_9_10", 0, 9, 5, 9, 1, 0, 0, 0);

        // bouncing inc in SET_HRS at 12 -> exactly one pulse -> 1
        press(0);
        press(1);
        press(1);
        expect_time("set_hrs_12", 1, 2, 0, 0);
        btn_inc = 1'b1; cycles(2);
        btn_inc = 1'b0; cycles(2);
        btn_inc = 1'b1; cycles(10);
        btn_inc = 1'b0; cycles(10);
        expect_time("bounce_one_pulse", 0, 1, 0, 0);

        // simultaneous mode+inc in RUN -> SET_HRS, inc discarded
        press(0);
        press(0);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        cycles(7);
        expect_time("both_press", 0, 1, 0, 0);
`ifdef TIME_SET_BLINK_EN
        check_eq("blink.e0",  int'(blank_hrs), 0);
        cycles(4);
        check_eq("blink.e4",  int'(blank_hrs), 0);
        cycles(1);
        check_eq("blink.e5",  int'(blank_hrs), 1);
        check_eq("blink.mins", int'(blank_mins), 0);
        cycles(5);
        check_eq("blink.e10", int'(blank_hrs), 0);
`else
        check_eq("noblink.e0.hrs", int'(blank_hrs), 0);
        cycles(5);
        check_eq("noblink.e5.hrs",  int'(blank_hrs),  0);
        check_eq("noblink.e5.mins", int'(blank_mins), 0);
        cycles(5);
`endif
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        cycles(8);
        cycles(700);
        expect_time("set_hrs_frozen", 0, 1, 0, 0);
        press(1);
        expect_time("set_hrs_after_both", 0, 2, 0, 0);

        // inc ignored in RUN
        press(0);
        press(0);
        press(1);
        expect_time("run_inc_ignored", 0, 2, 0, 0);
        check_eq("run.blank_hrs",  int'(blank_hrs),  0);
        check_eq("run.blank_mins", int'(blank_mins), 0);

        // reset while mode held: one press after release enters SET_HRS
        btn_mode = 1'b1;
        cycles(3);
        reset = 1'b1;
        cycles(2);
        expect_time("reset_mid_press", 1, 2, 0, 0);
        reset = 1'b0;
        cycles(20);
        btn_mode = 1'b0;
        cycles(700);
        expect_time("held_after_reset", 1, 2, 0, 0);
        press(1);
        expect_time("held_after_reset_inc", 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
